// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the datapath select stages.
package riscv_pkg;

    localparam int XLEN = 32;

    // Width of a binary select for n inputs; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry pipeline register (main + skid) with valid/ready handshake on both sides.
// Sustains one transfer per cycle; in_ready is registered (it is simply !skid_valid).
module pipe_skid_buffer #(
    parameter int PAY_W = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAY_W-1:0] in_payload,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PAY_W-1:0] out_payload,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [PAY_W-1:0] main_data_q, main_data_d;
    logic             main_valid_q, main_valid_d;
    logic [PAY_W-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             accept;
    logic             consume;

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_payload = main_data_q;

    assign accept  = in_valid && !skid_valid_q;
    assign consume = main_valid_q && out_ready;

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (consume || !main_valid_q) begin
            // Main is free this edge: the older skid beat has priority to keep FIFO order.
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = in_payload;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = in_payload;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/n_way_select_pipe.sv
// N-input select feeding a registered skid-buffered output stage.
// Optional macro N_WAY_SELECT_CHECK_EN adds an out-of-range select error bit carried with the data.
module n_way_select_pipe
    import riscv_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int NUM_IN = 4,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] sel_data;
    int               sel_idx;

    // Out-of-range selects yield zero data rather than an undefined slice.
    always_comb begin
        sel_data = '0;
        sel_idx  = int'(in_sel);
        if (sel_idx < NUM_IN) begin
            sel_data = in_data[sel_idx*WIDTH +: WIDTH];
        end
    end

`ifdef N_WAY_SELECT_CHECK_EN
    localparam int PAY_W = WIDTH + 1;

    logic             sel_err;
    logic [PAY_W-1:0] out_payload;

    assign sel_err = (int'(in_sel) >= NUM_IN);

    pipe_skid_buffer #(
        .PAY_W(PAY_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_payload ({sel_err, sel_data}),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_payload(out_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    assign out_err  = out_payload[WIDTH];
    assign out_data = out_payload[WIDTH-1:0];
`else
    pipe_skid_buffer #(
        .PAY_W(WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_payload (sel_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_payload(out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_n_way_select_pipe.sv
// Directed bench: a 4-input and a 3-input instance share clock and reset.
module tb_n_way_select_pipe;

    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [31:0] D2 = 32'h3333_3333;
    localparam logic [31:0] D3 = 32'h4444_4444;

`ifdef N_WAY_SELECT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;

    logic [127:0] in_data4;
    logic [1:0]   in_sel4;
    logic         in_valid4, in_ready4, out_err4, out_valid4, out_ready4;
    logic [31:0]  out_data4;

    logic [95:0]  in_data3;
    logic [1:0]   in_sel3;
    logic         in_valid3, in_ready3, out_err3, out_valid3, out_ready3;
    logic [31:0]  out_data3;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    n_way_select_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_sel(in_sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
        .out_err(out_err4), .out_valid(out_valid4), .out_ready(out_ready4)
    );

    n_way_select_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_err(out_err3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    initial begin
        tbl[0] = '{2'd2, D2};
        tbl[1] = '{2'd0, D0};
        tbl[2] = '{2'd1, D1};
        tbl[3] = '{2'd2, D2};
        tbl[4] = '{2'd3, D3};
        tbl[5] = '{2'd1, D1};

        rst        = 1'b1;
        in_data4   = {D3, D2, D1, D0};
        in_sel4    = 2'd0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        in_data3   = {D2, D1, D0};
        in_sel3    = 2'd0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid4), 32'd0);
        check("reset out_data",  out_data4, 32'd0);
        check("reset out_err",   32'(out_err4), 32'd0);
        check("reset in_ready",  32'(in_ready4), 32'd1);

        // Back-to-back stream: each beat shows up one cycle after it is driven.
        in_valid4 = 1'b1;
        in_sel4   = tbl[0].sel;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("stream[%0d] data", i), out_data4, tbl[i].exp_data);
            check($sformatf("stream[%0d] valid", i), 32'(out_valid4), 32'd1);
            check($sformatf("stream[%0d] in_ready", i), 32'(in_ready4), 32'd1);
            check($sformatf("stream[%0d] err", i), 32'(out_err4), 32'd0);
            if (i < 5) in_sel4 = tbl[i+1].sel;
            else       in_valid4 = 1'b0;
        end
        @(negedge clk);
        check("stream drained", 32'(out_valid4), 32'd0);

        // Back-pressure: three beats offered, two stored, then released in order.
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_sel4    = 2'd0;
        @(negedge clk);
        check("bp main data", out_data4, D0);
        check("bp in_ready after 1", 32'(in_ready4), 32'd1);
        in_sel4 = 2'd1;
        @(negedge clk);
        check("bp in_ready after 2", 32'(in_ready4), 32'd0);
        in_sel4 = 2'd2;
        @(negedge clk);
        check("bp hold data", out_data4, D0);
        check("bp hold valid", 32'(out_valid4), 32'd1);
        check("bp still full", 32'(in_ready4), 32'd0);
        out_ready4 = 1'b1;
        @(negedge clk);
        check("bp out 1", out_data4, D1);
        check("bp in_ready reopen", 32'(in_ready4), 32'd1);
        @(negedge clk);
        check("bp out 2", out_data4, D2);
        check("bp out 2 valid", 32'(out_valid4), 32'd1);
        in_valid4 = 1'b0;
        @(negedge clk);
        check("bp drained", 32'(out_valid4), 32'd0);

        // Reset with main and skid both full, then a normal beat.
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_sel4    = 2'd1;
        @(negedge clk);
        in_sel4 = 2'd2;
        @(negedge clk);
        check("prereset full", 32'(in_ready4), 32'd0);
        in_valid4 = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst out_valid", 32'(out_valid4), 32'd0);
        check("midrst in_ready", 32'(in_ready4), 32'd1);
        check("midrst out_data", out_data4, 32'd0);
        out_ready4 = 1'b1;
        @(negedge clk);
        check("midrst no ghost", 32'(out_valid4), 32'd0);
        in_valid4 = 1'b1;
        in_sel4   = 2'd3;
        @(negedge clk);
        in_valid4 = 1'b0;
        check("postrst data", out_data4, D3);
        check("postrst valid", 32'(out_valid4), 32'd1);
        @(negedge clk);
        check("postrst single", 32'(out_valid4), 32'd0);

        // Three-input instance: in-range then out-of-range select.
        in_valid3 = 1'b1;
        in_sel3   = 2'd1;
        @(negedge clk);
        check("n3 sel1 data", out_data3, D1);
        check("n3 sel1 err", 32'(out_err3), 32'd0);
        in_sel3 = 2'd3;
        @(negedge clk);
        check("n3 sel3 data", out_data3, 32'd0);
        check("n3 sel3 err", 32'(out_err3), 32'(ERR_EXP));
        check("n3 sel3 valid", 32'(out_valid3), 32'd1);
        in_sel3 = 2'd2;
        @(negedge clk);
        in_valid3 = 1'b0;
        check("n3 sel2 data", out_data3, D2);
        check("n3 sel2 err", 32'(out_err3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
